// File: rtl/debounce_scan_ctrl.sv
// debounce_scan_ctrl: shared, time-multiplexed debouncer for N slow inputs.
// A single prescaler triggers a round-robin scan that services one channel per
// clock. Debounced levels appear on o. Press and release events are queued in
// a first-word-fall-through FIFO with a valid/ready handshake.
// Optional feature macro: LONG_PRESS_EN adds per-channel long-press detection.
// Without this macro, ev_code[1] is always 0.
module debounce_scan_ctrl #(
    parameter int N              = 4,
    parameter int SAMPLE_TICKS   = 10000,
    parameter int STABLE_SAMPLES = 4,
    parameter int DEPTH          = 4,
    parameter int LONG_SAMPLES   = 200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         i,
    output logic [N-1:0]         o,
    output logic                 ev_valid,
    input  logic                 ev_ready,
    output logic [$clog2(N)-1:0] ev_ch,
    output logic [1:0]           ev_code,
    output logic                 ovf,
    input  logic                 ovf_clr
);

    localparam int PW = $clog2(N);
    localparam int CW = $clog2(STABLE_SAMPLES + 1);
    localparam int SW = $clog2(SAMPLE_TICKS);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = PW + 2;

    localparam logic [SW-1:0] PS_LAST  = SW'(SAMPLE_TICKS - 1);
    localparam logic [PW-1:0] LAST_CH  = PW'(N - 1);
    localparam logic [CW:0]   STABLE_W = (CW + 1)'(STABLE_SAMPLES);
    localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

    // Reject parameter sets the scan schedule or FIFO cannot support.
    if (N < 2 || N > 32 || SAMPLE_TICKS < N + 1 || STABLE_SAMPLES < 1 ||
        STABLE_SAMPLES > 255 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        LONG_SAMPLES < 1) begin : g_bad_params
        $error("debounce_scan_ctrl: unsupported parameter set");
    end

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    logic [N-1:0]    sync1_r, sync2_r, o_r;
    logic [SW-1:0]   presc_r;
    logic            strobe_s;
    state_t          state_r;
    logic [PW-1:0]   ptr_r;
    logic [CW-1:0]   cnt_r [N];

    logic            svc_s, s_cur_s, o_cur_s, flip_s, push_s;
    logic [CW-1:0]   cnt_cur_s;
    logic [CW:0]     cnt_inc_s;
    logic [1:0]      push_code_s;
    logic [EW-1:0]   push_data_s;

    logic [EW-1:0]   mem_r [DEPTH];
    logic [AW-1:0]   wr_r, rd_r, rd_nxt_s;
    logic [AW:0]     count_r, count_nxt_s;
    logic            full_s, pop_s, push_ok_s, drop_s;
    logic [EW-1:0]   head_s;
    logic            ev_valid_r, ovf_r;
    logic [PW-1:0]   ev_ch_r;
    logic [1:0]      ev_code_r;

`ifdef LONG_PRESS_EN
    localparam int HW = $clog2(LONG_SAMPLES + 1);
    localparam logic [HW-1:0] LONG_W = HW'(LONG_SAMPLES);
    logic [HW-1:0]   hold_r [N];
    logic [N-1:0]    fired_r;
    logic [HW-1:0]   hold_cur_s, hold_nxt_s;
    logic            long_s;
`endif

    // Two-flop synchronizer on every raw input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= {N{1'b0}};
            sync2_r <= {N{1'b0}};
        end else begin
            sync1_r <= i;
            sync2_r <= sync1_r;
        end
    end

    // Free-running prescaler, wraps every SAMPLE_TICKS clocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_r <= {SW{1'b0}};
        end else if (presc_r == PS_LAST) begin
            presc_r <= {SW{1'b0}};
        end else begin
            presc_r <= presc_r + SW'(1'b1);
        end
    end

    // Scan strobe is the single wrap cycle of the prescaler.
    always_comb begin
        strobe_s = 1'b0;
        if (presc_r == PS_LAST) begin
            strobe_s = 1'b1;
        end else begin
            strobe_s = 1'b0;
        end
    end

    // Scan scheduler: after each strobe, visit channels 0..N-1 once each.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            ptr_r   <= {PW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    ptr_r <= {PW{1'b0}};
                    if (strobe_s) state_r <= SCAN;
                end
                SCAN: begin
                    if (ptr_r == LAST_CH) begin
                        state_r <= IDLE;
                        ptr_r   <= {PW{1'b0}};
                    end else begin
                        ptr_r   <= ptr_r + PW'(1'b1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ptr_r   <= {PW{1'b0}};
                end
            endcase
        end
    end

    // Shared compare datapath for the channel currently being serviced.
    always_comb begin
        svc_s       = (state_r == SCAN);
        s_cur_s     = sync2_r[ptr_r];
        o_cur_s     = o_r[ptr_r];
        cnt_cur_s   = cnt_r[ptr_r];
        cnt_inc_s   = {1'b0, cnt_cur_s} + (CW + 1)'(1'b1);
        flip_s      = 1'b0;
        if (svc_s && (s_cur_s != o_cur_s) && (cnt_inc_s == STABLE_W)) begin
            flip_s = 1'b1;
        end else begin
            flip_s = 1'b0;
        end
`ifdef LONG_PRESS_EN
        hold_cur_s = hold_r[ptr_r];
        if (hold_cur_s == LONG_W) begin
            hold_nxt_s = hold_cur_s;
        end else begin
            hold_nxt_s = hold_cur_s + HW'(1'b1);
        end
        long_s = svc_s && o_cur_s && s_cur_s && (hold_nxt_s == LONG_W) && !fired_r[ptr_r];
        push_s = flip_s || long_s;
        // A level change always takes the single push slot over a long press.
        if (flip_s) begin
            push_code_s = {1'b0, s_cur_s};
        end else begin
            push_code_s = 2'b10;
        end
`else
        push_s = flip_s;
        if (flip_s) begin
            push_code_s = {1'b0, s_cur_s};
        end else begin
            push_code_s = 2'b00;
        end
`endif
        push_data_s = {ptr_r, push_code_s};
    end

    // Per-channel stability counter and debounced level update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_r <= {N{1'b0}};
            for (int k = 0; k < N; k++) cnt_r[k] <= {CW{1'b0}};
        end else if (svc_s) begin
            if (s_cur_s == o_cur_s) begin
                cnt_r[ptr_r] <= {CW{1'b0}};
            end else if (flip_s) begin
                o_r[ptr_r]   <= s_cur_s;
                cnt_r[ptr_r] <= {CW{1'b0}};
            end else begin
                cnt_r[ptr_r] <= cnt_inc_s[CW-1:0];
            end
        end else begin
            o_r <= o_r;
        end
    end

`ifdef LONG_PRESS_EN
    // Hold-time tracking for long-press detection; cleared when the level falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fired_r <= {N{1'b0}};
            for (int k = 0; k < N; k++) hold_r[k] <= {HW{1'b0}};
        end else if (svc_s) begin
            if (flip_s && o_cur_s) begin
                hold_r[ptr_r]  <= {HW{1'b0}};
                fired_r[ptr_r] <= 1'b0;
            end else if (o_cur_s && s_cur_s) begin
                hold_r[ptr_r] <= hold_nxt_s;
                if (long_s) fired_r[ptr_r] <= 1'b1;
            end else begin
                hold_r[ptr_r] <= hold_cur_s;
            end
        end else begin
            fired_r <= fired_r;
        end
    end
`endif

    // FIFO control: push and pop may coincide even when full.
    always_comb begin
        full_s    = (count_r == DEPTH_W);
        pop_s     = ev_valid_r && ev_ready;
        push_ok_s = push_s && (!full_s || pop_s);
        drop_s    = push_s && full_s && !pop_s;
        if (pop_s) begin
            rd_nxt_s = rd_r + AW'(1'b1);
        end else begin
            rd_nxt_s = rd_r;
        end
        case ({push_ok_s, pop_s})
            2'b10:   count_nxt_s = count_r + (AW + 1)'(1'b1);
            2'b01:   count_nxt_s = count_r - (AW + 1)'(1'b1);
            default: count_nxt_s = count_r;
        endcase
        // When the new head slot is the one being written now, bypass the array.
        if (push_ok_s && (wr_r == rd_nxt_s)) begin
            head_s = push_data_s;
        end else begin
            head_s = mem_r[rd_nxt_s];
        end
    end

    // FIFO storage, pointers, registered head outputs and sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) mem_r[k] <= {EW{1'b0}};
            wr_r       <= {AW{1'b0}};
            rd_r       <= {AW{1'b0}};
            count_r    <= {(AW + 1){1'b0}};
            ev_valid_r <= 1'b0;
            ev_ch_r    <= {PW{1'b0}};
            ev_code_r  <= 2'b00;
            ovf_r      <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_r] <= push_data_s;
                wr_r        <= wr_r + AW'(1'b1);
            end
            rd_r       <= rd_nxt_s;
            count_r    <= count_nxt_s;
            ev_valid_r <= (count_nxt_s != {(AW + 1){1'b0}});
            if (count_nxt_s != {(AW + 1){1'b0}}) begin
                {ev_ch_r, ev_code_r} <= head_s;
            end
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr) begin
                ovf_r <= 1'b0;
            end
        end
    end

    assign o        = o_r;
    assign ev_valid = ev_valid_r;
    assign ev_ch    = ev_ch_r;
    assign ev_code  = ev_code_r;
    assign ovf      = ovf_r;

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Directed testbench for debounce_scan_ctrl (N=4, SAMPLE_TICKS=8,
// STABLE_SAMPLES=4, DEPTH=4, LONG_SAMPLES=6). Timing reference: cyc counts
// rising edges since reset release. Scan strobe j services channel k at edge 8*j+1+k.
module tb_debounce_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] i = 4'b0000;
    logic [3:0] o;
    logic       ev_valid;
    logic       ev_ready = 1'b0;
    logic [1:0] ev_ch;
    logic [1:0] ev_code;
    logic       ovf;
    logic       ovf_clr = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int cyc;

    // Snapshot: {o, ev_valid, ev_ch, ev_code, ovf}
    wire [9:0] st = {o, ev_valid, ev_ch, ev_code, ovf};

    debounce_scan_ctrl #(.N(4), .SAMPLE_TICKS(8), .STABLE_SAMPLES(4),
                         .DEPTH(4), .LONG_SAMPLES(6)) dut (
        .clk(clk), .rst(rst), .i(i), .o(o), .ev_valid(ev_valid),
        .ev_ready(ev_ready), .ev_ch(ev_ch), .ev_code(ev_code),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic [3:0] iv, input logic rdy);
        rst = 1'b0;
        i = iv;
        ev_ready = rdy;
        ovf_clr = 1'b0;
        #23;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #1;
        vectors++;
        if (st !== 10'b0000_0_00_00_0) begin
            miscompares++;
            $display("FAIL reset_asserted: got %b want %b", st, 10'b0000_0_00_00_0);
        end
        do_reset(4'b0000, 1'b0);
        goto(20);
        vectors++;
        if (st !== 10'b0000_0_00_00_0) begin
            miscompares++;
            $display("FAIL reset_idle: got %b want %b", st, 10'b0000_0_00_00_0);
        end
    endtask

    task automatic test_press;
        do_reset(4'b0010, 1'b0);
        goto(33);
        vectors++;
        if (st !== 10'b0000_0_00_00_0) begin
            miscompares++;
            $display("FAIL press_before: got %b want %b", st, 10'b0000_0_00_00_0);
        end
        goto(34);
        vectors++;
        if (st !== 10'b0010_1_01_01_0) begin
            miscompares++;
            $display("FAIL press_flip: got %b want %b", st, 10'b0010_1_01_01_0);
        end
        goto(40);
        vectors++;
        if (st !== 10'b0010_1_01_01_0) begin
            miscompares++;
            $display("FAIL press_hold: got %b want %b", st, 10'b0010_1_01_01_0);
        end
        ev_ready = 1'b1;
        goto(41);
        vectors++;
        if (st !== 10'b0010_0_01_01_0) begin
            miscompares++;
            $display("FAIL press_pop: got %b want %b", st, 10'b0010_0_01_01_0);
        end
        ev_ready = 1'b0;
    endtask

    task automatic test_no_flip;
        do_reset(4'b0001, 1'b0);
        goto(26);
        i = 4'b0000;
        goto(34);
        vectors++;
        if (st !== 10'b0000_0_00_00_0) begin
            miscompares++;
            $display("FAIL glitch_no_flip: got %b want %b", st, 10'b0000_0_00_00_0);
        end
        i = 4'b0001;
        goto(64);
        vectors++;
        if (st !== 10'b0000_0_00_00_0) begin
            miscompares++;
            $display("FAIL glitch_restart: got %b want %b", st, 10'b0000_0_00_00_0);
        end
        goto(65);
        vectors++;
        if (st !== 10'b0001_1_00_01_0) begin
            miscompares++;
            $display("FAIL glitch_then_flip: got %b want %b", st, 10'b0001_1_00_01_0);
        end
    endtask

    task automatic test_back_to_back;
        do_reset(4'b1100, 1'b1);
        goto(34);
        vectors++;
        if (st !== 10'b0000_0_00_00_0) begin
            miscompares++;
            $display("FAIL b2b_before: got %b want %b", st, 10'b0000_0_00_00_0);
        end
        goto(35);
        vectors++;
        if (st !== 10'b0100_1_10_01_0) begin
            miscompares++;
            $display("FAIL b2b_ch2: got %b want %b", st, 10'b0100_1_10_01_0);
        end
        goto(36);
        vectors++;
        if (st !== 10'b1100_1_11_01_0) begin
            miscompares++;
            $display("FAIL b2b_ch3: got %b want %b", st, 10'b1100_1_11_01_0);
        end
        goto(37);
        vectors++;
        if (st !== 10'b1100_0_11_01_0) begin
            miscompares++;
            $display("FAIL b2b_empty: got %b want %b", st, 10'b1100_0_11_01_0);
        end
    endtask

    task automatic test_overflow;
        do_reset(4'b1111, 1'b0);
        goto(37);
        vectors++;
        if (st !== 10'b1111_1_00_01_0) begin
            miscompares++;
            $display("FAIL ovf_full: got %b want %b", st, 10'b1111_1_00_01_0);
        end
        i = 4'b1110;
        goto(64);
        vectors++;
        if (st !== 10'b1111_1_00_01_0) begin
            miscompares++;
            $display("FAIL ovf_before_drop: got %b want %b", st, 10'b1111_1_00_01_0);
        end
        goto(65);
        vectors++;
        if (st !== 10'b1110_1_00_01_1) begin
            miscompares++;
            $display("FAIL ovf_drop: got %b want %b", st, 10'b1110_1_00_01_1);
        end
        ovf_clr = 1'b1;
        goto(66);
        ovf_clr = 1'b0;
        vectors++;
        if (st !== 10'b1110_1_00_01_0) begin
            miscompares++;
            $display("FAIL ovf_clear: got %b want %b", st, 10'b1110_1_00_01_0);
        end
        ev_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if ({ev_valid, ev_ch, ev_code} !== {1'b1, 2'(k), 2'b01}) begin
                miscompares++;
                $display("FAIL ovf_drain_%0d: got %b want %b", k,
                         {ev_valid, ev_ch, ev_code}, {1'b1, 2'(k), 2'b01});
            end
            goto(67 + k);
        end
        vectors++;
        if (st !== 10'b1110_0_11_01_0) begin
            miscompares++;
            $display("FAIL ovf_drained: got %b want %b", st, 10'b1110_0_11_01_0);
        end
        ev_ready = 1'b0;
    endtask

    task automatic test_full_push_pop;
        do_reset(4'b1111, 1'b0);
        goto(37);
        i = 4'b1110;
        goto(64);
        ev_ready = 1'b1;
        goto(65);
        ev_ready = 1'b0;
        vectors++;
        if (st !== 10'b1110_1_01_01_0) begin
            miscompares++;
            $display("FAIL fullpp_head: got %b want %b", st, 10'b1110_1_01_01_0);
        end
        ev_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            vectors++;
            if ({ev_valid, ev_ch, ev_code} !== {1'b1, 2'(k % 4), ((k == 4) ? 2'b00 : 2'b01)}) begin
                miscompares++;
                $display("FAIL fullpp_drain_%0d: got %b want %b", k, {ev_valid, ev_ch, ev_code},
                         {1'b1, 2'(k % 4), ((k == 4) ? 2'b00 : 2'b01)});
            end
            goto(65 + k);
        end
        vectors++;
        if (ev_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fullpp_empty: got %b want %b", ev_valid, 1'b0);
        end
        ev_ready = 1'b0;
    endtask

    task automatic test_reset_midcount;
        do_reset(4'b1100, 1'b0);
        goto(26);
        i = 4'b1110;
        goto(42);
        vectors++;
        if (st !== 10'b1100_1_10_01_0) begin
            miscompares++;
            $display("FAIL midrst_before: got %b want %b", st, 10'b1100_1_10_01_0);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (st !== 10'b0000_0_00_00_0) begin
            miscompares++;
            $display("FAIL midrst_async: got %b want %b", st, 10'b0000_0_00_00_0);
        end
        @(negedge clk);
        rst = 1'b1;
        goto(33);
        vectors++;
        if (st !== 10'b0000_0_00_00_0) begin
            miscompares++;
            $display("FAIL midrst_restart: got %b want %b", st, 10'b0000_0_00_00_0);
        end
        goto(34);
        vectors++;
        if (st !== 10'b0010_1_01_01_0) begin
            miscompares++;
            $display("FAIL midrst_flip: got %b want %b", st, 10'b0010_1_01_01_0);
        end
    endtask

    task automatic test_long_press;
        int extra;
        extra = 0;
        do_reset(4'b0001, 1'b1);
        goto(33);
        vectors++;
        if (st !== 10'b0001_1_00_01_0) begin
            miscompares++;
            $display("FAIL long_press_ev: got %b want %b", st, 10'b0001_1_00_01_0);
        end
        goto(80);
        vectors++;
        if (ev_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL long_early: got %b want %b", ev_valid, 1'b0);
        end
        goto(81);
        vectors++;
`ifdef LONG_PRESS_EN
        if (st !== 10'b0001_1_00_10_0) begin
            miscompares++;
            $display("FAIL long_event: got %b want %b", st, 10'b0001_1_00_10_0);
        end
`else
        if (st !== 10'b0001_0_00_01_0) begin
            miscompares++;
            $display("FAIL long_absent: got %b want %b", st, 10'b0001_0_00_01_0);
        end
`endif
        for (int c = 82; c < 121; c++) begin
            goto(c);
            if (c == 90) i = 4'b0000;
            if (ev_valid) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("FAIL long_once: got %0d extra events want 0", extra);
        end
        goto(121);
        vectors++;
        if (st !== 10'b0000_1_00_00_0) begin
            miscompares++;
            $display("FAIL long_release: got %b want %b", st, 10'b0000_1_00_00_0);
        end
    endtask

    initial begin
        test_reset;
        test_press;
        test_no_flip;
        test_back_to_back;
        test_overflow;
        test_full_push_pop;
        test_reset_midcount;
        test_long_press;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/debounce_scan_ctrl.md
Name: debounce_scan_ctrl

Overview:
- Shared debounce engine for N slow inputs (buttons, switches, strap lines).
- One prescaler and a round-robin scan scheduler time-share a single compare/update datapath across all channels.
- Produces a debounced level vector plus a queued stream of press/release events over a valid/ready handshake.
- Sits between the raw pad inputs and the control/CSR logic; replaces per-pin debouncer instances.

Parameters:
- N, 4, number of input channels (2..32)
- SAMPLE_TICKS, 10000, clocks between scan strobes; must be >= N+1
- STABLE_SAMPLES, 4, consecutive differing samples needed to flip a channel (1..255)
- DEPTH, 4, event FIFO depth (power of 2, >= 2)
- LONG_SAMPLES, 200, samples held high before a long-press event (only with LONG_PRESS_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- i  in  N  raw asynchronous inputs
- o  out  N  debounced levels
- ev_valid  out  1  event available at FIFO head
- ev_ready  in  1  consumer accepts head event
- ev_ch  out  $clog2(N)  channel of head event
- ev_code  out  2  00 release, 01 press, 10 long press
- ovf  out  1  sticky: an event was dropped
- ovf_clr  in  1  clears ovf (single-cycle pulse)

Behaviour:
- Reset (rst low, asynchronous): o=0, all per-channel counters=0, synchronizers=0, prescaler=0, scan idle, FIFO empty, ev_valid=0, ev_ch=0, ev_code=0, ovf=0. Reset mid-scan or mid-count discards all partial state.
- Each i[k] passes through a 2-flop synchronizer (s[k]) before use.
- Prescaler counts 0..SAMPLE_TICKS-1. At wrap it pulses strobe for one cycle.
- Scan FSM has two states:
  - IDLE: waits for strobe, then moves to SCAN with ptr=0.
  - SCAN: services channel ptr each cycle; ptr increments; after ptr=N-1 returns to IDLE.
  - Exactly N service cycles per strobe, one channel per cycle.
- Service of channel k, with counter cnt[k] of width $clog2(STABLE_SAMPLES+1):
  - s[k]==o[k]: cnt[k] <= 0.
  - s[k]!=o[k] and cnt[k]+1 < STABLE_SAMPLES: cnt[k] <= cnt[k]+1.
  - s[k]!=o[k] and cnt[k]+1 == STABLE_SAMPLES: o[k] <= s[k], cnt[k] <= 0, and push event {k, s[k] ? 01 : 00}.
  - o[k] updates at the end of the service cycle.
- At most one push per cycle (one channel serviced per cycle), so the FIFO has a single write port.
- FIFO:
  - First-word-fall-through. ev_valid rises the cycle after the push.
  - Pop occurs when ev_valid && ev_ready.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full.
  - Push when full with no pop: event dropped, ovf <= 1, queued contents untouched.
- ovf: set has priority over ovf_clr in the same cycle.
- Event order: scan order within a strobe (lower channel first), then strobe order.
- ev_ch/ev_code hold stable while ev_valid && !ev_ready.

Optional Feature:
- Macro LONG_PRESS_EN.
- Defined:
  - Per-channel hold counter, width $clog2(LONG_SAMPLES+1), plus one fired flag.
  - At each service where o[k]==1 and s[k]==1, the hold counter increments, saturating at LONG_SAMPLES.
  - On reaching LONG_SAMPLES with fired clear: push {k,10} and set fired.
  - Hold counter and fired clear when o[k] falls or on reset.
  - If the same service cycle would push both a press/release and a long press, only the press/release is pushed.
- Undefined: no hold logic is instantiated; ev_code[1] is tied to 0.

Test Plan (N=4, SAMPLE_TICKS=8, STABLE_SAMPLES=4, DEPTH=4, LONG_SAMPLES=6):
- i[1] 0->1 and held -> o[1] rises in ch1's service cycle of the 4th strobe after s[1]=1; one event {1,01}, ev_valid high the next cycle; no other o bits change.
- i[0] high for 3 strobes then low -> o[0] stays 0, no event, cnt[0] returns to 0.
- i[2] and i[3] rise in the same clock, ev_ready=1 -> both flip on the same strobe; events {2,01} then {3,01} on consecutive cycles.
- ev_ready=0; 5 edges generate 5 events -> 4 queued in order, ovf=1, 5th lost; ovf_clr pulse -> ovf=0; draining with ev_ready=1 yields exactly 4 events.
- rst asserted while cnt[1]=2 and FIFO holds 2 events -> immediately o=0, ev_valid=0, ovf=0; after release, 3 more matching samples do not flip o[1] (counting restarts).
- LONG_PRESS_EN defined, i[0] held high -> {0,01} then, 6 strobes later, {0,10} exactly once; release -> {0,00}. Macro undefined -> {0,10} never appears.
